// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and small helpers shared by the
// VGA sync generator and its tick sampler.
package vga_timing_pkg;

    localparam int unsigned CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // Inclusive window test used for the sync pulse decode.
    function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Samples a slow divided clock as data and emits a one-cycle enable on each
// of its rising edges; shared by the VGA, segment and sound clock consumers.
module tick_gen (
    input  logic clk,
    input  logic clr,
    input  logic sig_i,
    output logic tick_o
);

    logic d1_q;
    logic d2_q;

    // Both stages reset high so a signal already high at release is not an edge.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            d1_q <= 1'b1;
            d2_q <= 1'b1;
        end else begin
            d1_q <= sig_i;
            d2_q <= d1_q;
        end
    end

    assign tick_o = d1_q & ~d2_q;

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters advanced by the pixel enable,
// with sync, visible-area and frame-start outputs registered from next state.
module vga_sync
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             dclk,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic [CNT_W-1:0] px,
    output logic [CNT_W-1:0] py,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_MAX   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_MAX   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t H_VIS   = cnt_t'(H_VISIBLE);
    localparam cnt_t V_VIS   = cnt_t'(V_VISIBLE);
    localparam cnt_t HS_LO   = cnt_t'(H_VISIBLE + H_FP);
    localparam cnt_t HS_HI   = cnt_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam cnt_t VS_LO   = cnt_t'(V_VISIBLE + V_FP);
    localparam cnt_t VS_HI   = cnt_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic pix_en;

    cnt_t hc_q, hc_d;
    cnt_t vc_q, vc_d;
    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic video_on_q, video_on_d;
    logic frame_start_q, frame_start_d;

    tick_gen u_tick_gen (
        .clk    (clk),
        .clr    (clr),
        .sig_i  (dclk),
        .tick_o (pix_en)
    );

    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (pix_en) begin
            if (hc_q == H_MAX) begin
                hc_d = '0;
                vc_d = (vc_q == V_MAX) ? '0 : vc_q + cnt_t'(1);
            end else begin
                hc_d = hc_q + cnt_t'(1);
            end
        end
    end

    // Decode from next-state counters so outputs line up with px/py.
    always_comb begin
        hsync_d       = ~in_window(hc_d, HS_LO, HS_HI);
        vsync_d       = ~in_window(vc_d, VS_LO, VS_HI);
        video_on_d    = (hc_d < H_VIS) && (vc_d < V_VIS);
        frame_start_d = pix_en && (hc_d == '0) && (vc_d == '0);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            hc_q          <= H_MAX;
            vc_q          <= V_MAX;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign px          = hc_q;
    assign py          = vc_q;
    assign frame_start = frame_start_q;

endmodule
